// File: rtl/gnrl_iq_pkg.sv
// rtl/gnrl_iq_pkg.sv - shared IQ pack/unpack definitions for the decimator and split interpolator
package gnrl_iq_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_INT_WIDTH  = 16;

    // Combined stream order: the I word always precedes its Q word.
    localparam bit WORD_ORDER_I_FIRST = 1'b1;

    typedef enum logic [1:0] {
        S_WAIT_I = 2'd0,
        S_WAIT_Q = 2'd1,
        S_EMIT   = 2'd2
    } iq_state_t;

    // A repeat factor of zero still emits the pair once.
    function automatic logic [DEFAULT_INT_WIDTH-1:0] repeat_load_value(
        input logic [DEFAULT_INT_WIDTH-1:0] fact
    );
        return (fact == '0) ? DEFAULT_INT_WIDTH'(1) : fact;
    endfunction

endpackage

// File: rtl/gnrl_repeat_counter.sv
// rtl/gnrl_repeat_counter.sv - zero-order-hold repeat counter with last flag
module gnrl_repeat_counter #(
    parameter int INT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [INT_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 last
);

    logic [INT_WIDTH-1:0] count;
    logic [INT_WIDTH-1:0] load_eff;

    assign load_eff = (load_val == '0) ? INT_WIDTH'(1) : load_val;
    assign last     = (count == INT_WIDTH'(1));

    // Load wins over decrement; decrement stops at zero so the count never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_eff;
        end else if (dec && count != '0) begin
            count <= count - INT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/gnrl_iq_split_interpolator.sv
// rtl/gnrl_iq_split_interpolator.sv - de-interleaves I/Q word stream and repeats each pair interp_fact times
module gnrl_iq_split_interpolator
    import gnrl_iq_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int INT_WIDTH  = DEFAULT_INT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] datain,
    input  logic                  in_valid,
    input  logic                  in_sync,
    output logic                  in_ready,
    input  logic [INT_WIDTH-1:0]  interp_fact,
    output logic [DATA_WIDTH-1:0] dataI,
    output logic [DATA_WIDTH-1:0] dataQ,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  pair_err
);

    iq_state_t             state;
    logic [DATA_WIDTH-1:0] i_hold;
    logic                  in_ready_r;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  q_capture;
    logic                  cnt_last;

    // Held low combinationally while reset is asserted, whatever the state.
    assign in_ready  = in_ready_r & ~RESET;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign q_capture = (state == S_WAIT_Q) && in_xfer && !in_sync;

    gnrl_repeat_counter #(
        .INT_WIDTH (INT_WIDTH)
    ) u_repeat_counter (
        .clk      (CLK),
        .reset    (RESET),
        .load     (q_capture),
        .load_val (interp_fact),
        .dec      (out_xfer),
        .last     (cnt_last)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_WAIT_I;
            i_hold     <= '0;
            in_ready_r <= 1'b1;
            out_valid  <= 1'b0;
            pair_err   <= 1'b0;
            dataI      <= '0;
            dataQ      <= '0;
        end else begin
            pair_err <= 1'b0;
            case (state)
                S_WAIT_I: begin
                    if (in_xfer) begin
                        i_hold <= datain;
                        state  <= S_WAIT_Q;
                    end
                end
                S_WAIT_Q: begin
                    if (in_xfer) begin
                        if (in_sync) begin
                            // A second frame start: the pending I is orphaned.
                            i_hold   <= datain;
                            pair_err <= 1'b1;
                        end else begin
                            dataI      <= i_hold;
                            dataQ      <= datain;
                            out_valid  <= 1'b1;
                            in_ready_r <= 1'b0;
                            state      <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_xfer && cnt_last) begin
                        out_valid  <= 1'b0;
                        in_ready_r <= 1'b1;
                        state      <= S_WAIT_I;
                    end
                end
                default: begin
                    state      <= S_WAIT_I;
                    out_valid  <= 1'b0;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gnrl_iq_split_interpolator.sv
// tb/tb_gnrl_iq_split_interpolator.sv - scoreboard bench for the IQ split interpolator
module tb_gnrl_iq_split_interpolator;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] datain;
    logic        in_valid;
    logic        in_sync;
    logic        in_ready;
    logic [15:0] interp_fact;
    logic [31:0] dataI;
    logic [31:0] dataQ;
    logic        out_valid;
    logic        out_ready;
    logic        pair_err;

    int          errors = 0;
    int          checks = 0;
    int          xfer_count = 0;
    bit          rand_ready = 1'b0;
    logic [63:0] exp_q[$];

    gnrl_iq_split_interpolator dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .datain      (datain),
        .in_valid    (in_valid),
        .in_sync     (in_sync),
        .in_ready    (in_ready),
        .interp_fact (interp_fact),
        .dataI       (dataI),
        .dataQ       (dataQ),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pair_err    (pair_err)
    );

    always #5 CLK = ~CLK;

    // Every output transfer must match the next queued (I,Q) in order.
    always @(negedge CLK) begin
        if (!RESET && out_valid && out_ready) begin
            logic [63:0] e;
            xfer_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got I=%h Q=%h, expected no transfer", dataI, dataQ);
            end else begin
                e = exp_q.pop_front();
                if ({dataI, dataQ} !== e) begin
                    errors++;
                    $display("FAIL sb_data: got I=%h Q=%h, expected I=%h Q=%h", dataI, dataQ, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic step_ready();
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_word(input logic [31:0] d, input logic s);
        int n = 0;
        datain   = d;
        in_sync  = s;
        in_valid = 1'b1;
        @(negedge CLK);
        while (!in_ready && n < 200) begin
            @(posedge CLK); #1; step_ready();
            @(negedge CLK);
            n++;
        end
        if (!in_ready) begin
            errors++; checks++;
            $display("FAIL send_timeout: in_ready=%b, expected 1 within 200 cycles", in_ready);
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        step_ready();
    endtask

    task automatic send_pair(input logic [31:0] i, input logic [31:0] q, input logic [15:0] fact);
        int reps = (fact == 0) ? 1 : int'(fact);
        interp_fact = fact;
        for (int k = 0; k < reps; k++) exp_q.push_back({i, q});
        send_word(i, 1'b0);
        send_word(q, 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            @(posedge CLK); #1; step_ready();
            @(negedge CLK);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL idle_timeout: pending=%0d out_valid=%b, expected 0 and 0", exp_q.size(), out_valid);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; in_valid = 1'b0; in_sync = 1'b0; datain = '0;
        interp_fact = 16'd1; out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready_during: got %b expected 0", in_ready);
        end
        @(posedge CLK); #1; RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if ({in_ready, out_valid, pair_err} !== 3'b100) begin
            errors++; $display("FAIL reset_flags: got rdy/ov/err=%b expected 100", {in_ready, out_valid, pair_err});
        end
        checks++;
        if ({dataI, dataQ} !== 64'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {dataI, dataQ});
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_basic_interp4();
        send_pair(32'h10, 32'h20, 16'd4);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            checks++;
            if ({out_valid, in_ready} !== 2'b10 || dataI !== 32'h10 || dataQ !== 32'h20) begin
                errors++;
                $display("FAIL basic_emit%0d: got ov=%b rdy=%b I=%h Q=%h expected ov=1 rdy=0 I=10 Q=20", k, out_valid, in_ready, dataI, dataQ);
            end
        end
        @(negedge CLK);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL basic_end: got ov=%b rdy=%b expected ov=0 rdy=1", out_valid, in_ready);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_zero_fact();
        int base = xfer_count;
        send_pair(32'd5, 32'd7, 16'd0);
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b1 || dataI !== 32'd5 || dataQ !== 32'd7) begin
            errors++; $display("FAIL zero_emit: got ov=%b I=%h Q=%h expected ov=1 I=5 Q=7", out_valid, dataI, dataQ);
        end
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || xfer_count - base != 1) begin
            errors++; $display("FAIL zero_count: got ov=%b xfers=%0d expected ov=0 xfers=1", out_valid, xfer_count - base);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_stall();
        int base = xfer_count;
        out_ready = 1'b0;
        send_pair(32'd1, 32'd2, 16'd3);
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            checks++;
            if (out_valid !== 1'b1 || dataI !== 32'd1 || dataQ !== 32'd2) begin
                errors++; $display("FAIL stall_hold%0d: got ov=%b I=%h Q=%h expected ov=1 I=1 Q=2", k, out_valid, dataI, dataQ);
            end
        end
        @(posedge CLK); #1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checks++;
            if (out_valid !== 1'b1 || dataI !== 32'd1 || dataQ !== 32'd2) begin
                errors++; $display("FAIL stall_drain%0d: got ov=%b I=%h Q=%h expected ov=1 I=1 Q=2", k, out_valid, dataI, dataQ);
            end
        end
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || xfer_count - base != 3) begin
            errors++; $display("FAIL stall_count: got ov=%b xfers=%0d expected ov=0 xfers=3", out_valid, xfer_count - base);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_resync();
        interp_fact = 16'd2;
        exp_q.push_back({32'hB, 32'hC});
        exp_q.push_back({32'hB, 32'hC});
        send_word(32'hA, 1'b0);
        send_word(32'hB, 1'b1);
        @(negedge CLK);
        checks++;
        if (pair_err !== 1'b1) begin
            errors++; $display("FAIL resync_pulse: got pair_err=%b expected 1", pair_err);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (pair_err !== 1'b0) begin
            errors++; $display("FAIL resync_one_cycle: got pair_err=%b expected 0", pair_err);
        end
        @(posedge CLK); #1;
        send_word(32'hC, 1'b0);
        wait_idle();
    endtask

    task automatic test_reset_mid_emit();
        int base;
        send_pair(32'h55, 32'h66, 16'd8);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || {dataI, dataQ} !== 64'h0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_state: got ov=%b data=%h rdy=%b expected ov=0 data=0 rdy=1", out_valid, {dataI, dataQ}, in_ready);
        end
        @(posedge CLK); #1;
        base = xfer_count;
        send_pair(32'd3, 32'd4, 16'd8);
        wait_idle();
        checks++;
        if (xfer_count - base != 8) begin
            errors++; $display("FAIL midreset_count: got xfers=%0d expected 8", xfer_count - base);
        end
    endtask

    task automatic test_random();
        int base = xfer_count;
        int total = 0;
        rand_ready = 1'b1;
        for (int p = 0; p < 100; p++) begin
            logic [15:0] f = 16'($urandom_range(1, 5));
            total += int'(f);
            send_pair($urandom % 8000, $urandom % 8000, f);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK); #1; step_ready();
            end
        end
        wait_idle();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        wait_idle();
        checks++;
        if (xfer_count - base != total) begin
            errors++; $display("FAIL random_count: got xfers=%0d expected %0d", xfer_count - base, total);
        end
    endtask

    initial begin
        test_reset();
        test_basic_interp4();
        test_zero_fact();
        test_stall();
        test_resync();
        test_reset_mid_emit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
